// File: rtl/uart_pkg.sv
// Shared UART types and constants: FSM state encodings, data width and baud divider helper.
package uart_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned BIT_W  = $clog2(DATA_W);

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_WAIT,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_e;

  // Half-bit divider; a degenerate ratio still yields a tick every clock.
  function automatic int unsigned calc_div(input int unsigned clk_hz, input int unsigned baud);
    int unsigned d;
    d = clk_hz / (2 * baud);
    return (d == 0) ? 1 : d;
  endfunction

endpackage

// File: rtl/uart_echo_if.sv
// Serial line and receive/transmit status bundle of the echo block.
interface uart_echo_if;
  import uart_pkg::*;

  logic              rx;
  logic              tx;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_frame_err;
  logic              tx_busy;

  modport master (
    output rx,
    input  tx, rx_data, rx_valid, rx_frame_err, tx_busy
  );

  modport slave (
    input  rx,
    output tx, rx_data, rx_valid, rx_frame_err, tx_busy
  );
endinterface

// File: rtl/clock_divider.sv
// Free-running half-bit tick generator: one-clock pulse every DIV clocks.
module clock_divider #(
  parameter int unsigned DIV = 1406
) (
  input  logic clk,
  input  logic rst,
  output logic clk_en_c
);
  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    clk_en_c = (cnt_q == CNT_W'(DIV - 1));
    cnt_d    = clk_en_c ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
endmodule

// File: rtl/uart_rx.sv
// 8N1 receiver running on half-bit ticks; samples each bit every second tick.
module uart_rx
  import uart_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clk_en,
  input  logic              rx,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              rx_frame_err
);
  logic              sync1_q, sync2_q;
  rx_state_e         state_q, state_d;
  logic              phase_q, phase_d;
  logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              err_q, err_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= rx;
      sync2_q <= sync1_q;
    end
  end

  // phase_q marks the tick that lands mid-cell, where the line is sampled.
  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    err_d     = 1'b0;
    if (clk_en) begin
      case (state_q)
        RX_IDLE: if (!sync2_q) state_d = RX_START;
        RX_START: begin
          if (!sync2_q) begin
            state_d   = RX_DATA;
            phase_d   = 1'b0;
            bit_cnt_d = '0;
          end else begin
            state_d = RX_IDLE;
          end
        end
        RX_DATA: begin
          phase_d = ~phase_q;
          if (phase_q) begin
            shift_d   = {sync2_q, shift_q[DATA_W-1:1]};
            bit_cnt_d = bit_cnt_q + 1'b1;
            if (bit_cnt_q == BIT_W'(DATA_W - 1)) state_d = RX_STOP;
          end
        end
        RX_STOP: begin
          phase_d = ~phase_q;
          if (phase_q) begin
            state_d = RX_IDLE;
            if (sync2_q) begin
              data_d  = shift_q;
              valid_d = 1'b1;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        default: state_d = RX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= RX_IDLE;
      phase_q   <= 1'b0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
    end
  end

  assign rx_data      = data_q;
  assign rx_valid     = valid_q;
  assign rx_frame_err = err_q;
endmodule

// File: rtl/uart_tx.sv
// 8N1 transmitter; each bit cell spans two half-bit ticks.
module uart_tx
  import uart_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clk_en,
  input  logic              tx_start,
  input  logic [DATA_W-1:0] tx_data,
  output logic              tx,
  output logic              tx_busy
);
  tx_state_e         state_q, state_d;
  logic              phase_q, phase_d;
  logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              tx_q, tx_d;
  logic              busy_q, busy_d;

  // Line changes only on the second tick of a cell; WAIT aligns the frame to the tick grid.
  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    busy_d    = busy_q;
    case (state_q)
      TX_IDLE: begin
        if (tx_start) begin
          shift_d = tx_data;
          busy_d  = 1'b1;
          state_d = TX_WAIT;
        end
      end
      TX_WAIT: begin
        if (clk_en) begin
          state_d = TX_START;
          tx_d    = 1'b0;
          phase_d = 1'b0;
        end
      end
      TX_START: begin
        if (clk_en) begin
          phase_d = ~phase_q;
          if (phase_q) begin
            state_d   = TX_DATA;
            tx_d      = shift_q[0];
            bit_cnt_d = '0;
          end
        end
      end
      TX_DATA: begin
        if (clk_en) begin
          phase_d = ~phase_q;
          if (phase_q) begin
            if (bit_cnt_q == BIT_W'(DATA_W - 1)) begin
              state_d = TX_STOP;
              tx_d    = 1'b1;
            end else begin
              shift_d   = {1'b0, shift_q[DATA_W-1:1]};
              tx_d      = shift_q[1];
              bit_cnt_d = bit_cnt_q + 1'b1;
            end
          end
        end
      end
      TX_STOP: begin
        if (clk_en) begin
          phase_d = ~phase_q;
          if (phase_q) begin
            state_d = TX_IDLE;
            busy_d  = 1'b0;
          end
        end
      end
      default: begin
        state_d = TX_IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= TX_IDLE;
      phase_q   <= 1'b0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
    end
  end

  assign tx      = tx_q;
  assign tx_busy = busy_q;
endmodule

// File: rtl/uart_echo.sv
// UART loopback: every correctly received byte is retransmitted; last byte wins while one is pending.
module uart_echo
  import uart_pkg::*;
#(
  parameter int unsigned INPUT_CLOCK = 27000000,
  parameter int unsigned BAUD_RATE   = 9600
) (
  input  logic        clk,
  input  logic        rst,
  uart_echo_if.slave  bus
);
  localparam int unsigned DIV = calc_div(INPUT_CLOCK, BAUD_RATE);

  logic              clk_en;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_frame_err;
  logic              tx;
  logic              tx_busy;
  logic              tx_start_c;
  logic              pending_q, pending_d;
  logic [DATA_W-1:0] hold_q, hold_d;

  clock_divider #(.DIV(DIV)) u_div (
    .clk      (clk),
    .rst      (rst),
    .clk_en_c (clk_en)
  );

  uart_rx u_rx (
    .clk          (clk),
    .rst          (rst),
    .clk_en       (clk_en),
    .rx           (bus.rx),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_frame_err (rx_frame_err)
  );

  uart_tx u_tx (
    .clk      (clk),
    .rst      (rst),
    .clk_en   (clk_en),
    .tx_start (tx_start_c),
    .tx_data  (hold_q),
    .tx       (tx),
    .tx_busy  (tx_busy)
  );

  // A byte arriving in the same cycle as the launch stays pending for the next frame.
  always_comb begin
    tx_start_c = pending_q && !tx_busy;
    pending_d  = pending_q;
    hold_d     = hold_q;
    if (tx_start_c) pending_d = 1'b0;
    if (rx_valid) begin
      pending_d = 1'b1;
      hold_d    = rx_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q <= 1'b0;
      hold_q    <= '0;
    end else begin
      pending_q <= pending_d;
      hold_q    <= hold_d;
    end
  end

  assign bus.tx           = tx;
  assign bus.tx_busy      = tx_busy;
  assign bus.rx_data      = rx_data;
  assign bus.rx_valid     = rx_valid;
  assign bus.rx_frame_err = rx_frame_err;
endmodule

// File: tb/tb_uart_echo.sv
// Scoreboard bench for uart_echo at 16 clk/bit: random frames, glitches, bad stops, reset mid-echo.
module tb_uart_echo;
  import uart_pkg::*;

  localparam int unsigned BIT_CLK  = 16;
  localparam int unsigned TICK_CLK = 8;

  typedef struct {
    bit         err;
    logic [7:0] data;
  } rx_ev_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        div_en;
  int unsigned cyc;
  int          checks   = 0;
  int          failures = 0;

  rx_ev_t      rx_q[$];
  logic [7:0]  echo_q[$];
  logic [7:0]  last_good = 8'h00;
  rx_ev_t      mon_ev;

  uart_echo_if u_if();

  uart_echo #(.INPUT_CLOCK(16), .BAUD_RATE(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if)
  );

  clock_divider #(.DIV(calc_div(1000, 50))) u_div (
    .clk      (clk),
    .rst      (rst),
    .clk_en_c (div_en)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_good(input logic [7:0] b);
    rx_ev_t e;
    e.err  = 1'b0;
    e.data = b;
    rx_q.push_back(e);
    echo_q.push_back(b);
    last_good = b;
  endtask

  task automatic expect_bad();
    rx_ev_t e;
    e.err  = 1'b1;
    e.data = last_good;
    rx_q.push_back(e);
  endtask

  // Start the frame d clocks before a receiver tick so every sample lands well inside its bit.
  task automatic align_start(input int unsigned d);
    for (int i = 0; i < int'(TICK_CLK); i++) begin
      @(negedge clk);
      if ((cyc % TICK_CLK) == ((TICK_CLK - d) % TICK_CLK)) break;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    logic [9:0] bits;
    bits = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      u_if.rx = bits[i];
      repeat (BIT_CLK) @(negedge clk);
    end
    u_if.rx = 1'b1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((rx_q.size() != 0 || echo_q.size() != 0 || u_if.tx_busy || !u_if.tx) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) check("drain_timeout_cycles", 32'(n), 32'd0);
    repeat (24) @(negedge clk);
  endtask

  task automatic quiet_window(input string name, input int n);
    int bad;
    bad = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (u_if.tx !== 1'b1 || u_if.rx_valid !== 1'b0 || u_if.rx_frame_err !== 1'b0) bad++;
    end
    check(name, 32'(bad), 32'd0);
  endtask

  // Receive-side monitor: every rx_valid / rx_frame_err pulse must match the oldest expected event.
  always @(negedge clk) begin
    if (!rst && (u_if.rx_valid || u_if.rx_frame_err)) begin
      if (rx_q.size() == 0) begin
        check("rx_unexpected_event", 32'({u_if.rx_valid, u_if.rx_frame_err}), 32'd0);
      end else begin
        mon_ev = rx_q.pop_front();
        check("rx_kind", 32'({u_if.rx_valid, u_if.rx_frame_err}), mon_ev.err ? 32'd1 : 32'd2);
        check("rx_data", 32'(u_if.rx_data), 32'(mon_ev.data));
      end
    end
  end

  // Transmit-side monitor: decode each frame cell by cell, 16 clocks per cell, busy throughout.
  initial begin : tx_mon
    logic [9:0] bits;
    logic [7:0] exp_b;
    bit         have;
    bit         aborted;
    bit         first;
    int         match;
    int         busy_n;
    forever begin
      @(negedge clk);
      if (rst || u_if.tx) continue;
      if (echo_q.size() == 0) begin
        check("tx_unexpected_frame", 32'(u_if.tx), 32'd1);
        have  = 1'b0;
        exp_b = 8'h00;
      end else begin
        exp_b = echo_q.pop_front();
        have  = 1'b1;
      end
      bits    = {1'b1, exp_b, 1'b0};
      aborted = 1'b0;
      first   = 1'b1;
      busy_n  = 0;
      for (int c = 0; c < 10; c++) begin
        match = 0;
        for (int j = 0; j < int'(BIT_CLK); j++) begin
          if (!first) @(negedge clk);
          first = 1'b0;
          if (rst) begin
            aborted = 1'b1;
            break;
          end
          if (u_if.tx === bits[c]) match++;
          if (u_if.tx_busy === 1'b1) busy_n++;
        end
        if (aborted) break;
        if (have) check($sformatf("tx_cell%0d_byte%02h", c, exp_b), 32'(match), 32'(BIT_CLK));
      end
      if (!aborted && have) check("tx_busy_frame", 32'(busy_n), 32'(10 * BIT_CLK));
    end
  end

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: time budget exceeded at %0t", $time);
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : stim
    int n;
    int unsigned kind;
    logic [7:0] a;
    logic [7:0] b;

    u_if.rx = 1'b1;
    rst     = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_tx", 32'(u_if.tx), 32'd1);
    check("rst_tx_busy", 32'(u_if.tx_busy), 32'd0);
    check("rst_rx_valid", 32'(u_if.rx_valid), 32'd0);
    check("rst_rx_frame_err", 32'(u_if.rx_frame_err), 32'd0);
    check("rst_rx_data", 32'(u_if.rx_data), 32'd0);
    rst = 1'b0;

    // Divider at DIV=10: tick visible in the cycle before every 10th edge after reset.
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      check("div_tick", 32'(div_en), ((cyc % 10) == 9) ? 32'd1 : 32'd0);
    end
    wait_idle();

    // 0x55 echo
    align_start(3);
    expect_good(8'h55);
    send_frame(8'h55, 1'b1);
    wait_idle();

    // short glitch on rx
    u_if.rx = 1'b0;
    repeat (3) @(negedge clk);
    u_if.rx = 1'b1;
    quiet_window("glitch_quiet", 200);

    // bad stop bit
    align_start(5);
    expect_bad();
    send_frame(8'hA5, 1'b0);
    wait_idle();

    // back-to-back pair
    align_start(4);
    expect_good(8'hA5);
    expect_good(8'h3C);
    send_frame(8'hA5, 1'b1);
    send_frame(8'h3C, 1'b1);
    wait_idle();

    // reset in the middle of echoing 0xFF
    align_start(6);
    expect_good(8'hFF);
    send_frame(8'hFF, 1'b1);
    n = 0;
    while (!u_if.tx_busy && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("echo_started", 32'(u_if.tx_busy), 32'd1);
    repeat (40) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_tx", 32'(u_if.tx), 32'd1);
    check("midrst_tx_busy", 32'(u_if.tx_busy), 32'd0);
    check("midrst_rx_valid", 32'(u_if.rx_valid), 32'd0);
    check("midrst_rx_data", 32'(u_if.rx_data), 32'd0);
    echo_q.delete();
    rx_q.delete();
    last_good = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    quiet_window("post_rst_quiet", 400);

    // random traffic
    for (int t = 0; t < 12; t++) begin
      kind = $urandom_range(0, 3);
      a    = 8'($urandom);
      b    = 8'($urandom);
      case (kind)
        0: begin
          align_start($urandom_range(3, 7));
          expect_good(a);
          send_frame(a, 1'b1);
          wait_idle();
        end
        1: begin
          align_start($urandom_range(3, 7));
          expect_good(a);
          expect_good(b);
          send_frame(a, 1'b1);
          send_frame(b, 1'b1);
          wait_idle();
        end
        2: begin
          align_start($urandom_range(3, 7));
          expect_bad();
          send_frame(a, 1'b0);
          wait_idle();
        end
        default: begin
          repeat ($urandom_range(0, 7)) @(negedge clk);
          u_if.rx = 1'b0;
          repeat (3) @(negedge clk);
          u_if.rx = 1'b1;
          quiet_window("rand_glitch_quiet", 100);
        end
      endcase
    end

    check("rx_queue_drained", 32'(rx_q.size()), 32'd0);
    check("echo_queue_drained", 32'(echo_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/uart_echo.md
UART_ECHO -- requirements
Module: uart_echo

Interface
REQ-001 Parameter INPUT_CLOCK, default 27000000, system clock frequency in Hz.
REQ-002 Parameter BAUD_RATE, default 9600, serial bit rate in bit/s.
REQ-003 clk  input  1  system clock; all logic on rising edge; one clock domain.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 rx  input  1  serial receive line, idle high, asynchronous to clk.
REQ-006 tx  output  1  serial transmit line, idle high.
REQ-007 rx_data  output  8  last correctly received byte.
REQ-008 rx_valid  output  1  one-clk pulse when rx_data updates.
REQ-009 rx_frame_err  output  1  one-clk pulse when a frame's stop bit samples 0.
REQ-010 tx_busy  output  1  high while the transmitter holds or sends a frame.

Function
REQ-011 Frame format SHALL be 8N1: start 0, data bits 0..7 LSB first, stop 1.
REQ-012 Divider SHALL be DIV = INPUT_CLOCK / (2*BAUD_RATE), integer truncation; 27 MHz at 9600 gives DIV = 1406.
REQ-013 Divider counter SHALL count 0..DIV-1 and wrap to 0, asserting clk_en for exactly one clk on the DIV-1 count; clk_en is the half-bit tick.
REQ-014 rx SHALL pass through a 2-flop synchronizer before use.
REQ-015 RX states: IDLE, START, DATA, STOP; all transitions are evaluated only on clk_en.
REQ-016 RX IDLE->START when synchronized rx = 0 on a tick.
REQ-017 RX START: on the next tick (mid start bit), rx = 0 -> DATA; rx = 1 -> IDLE, discarded as a glitch.
REQ-018 RX DATA SHALL sample one bit every 2 ticks, 8 bits, shifting LSB first, then go to STOP.
REQ-019 RX STOP samples 2 ticks after the last data bit: rx = 1 loads rx_data and pulses rx_valid; rx = 0 leaves rx_data unchanged and pulses rx_frame_err; both return to IDLE.
REQ-020 TX states: IDLE, WAIT, START, DATA, STOP.
REQ-021 TX IDLE: tx_start latches the byte, raises tx_busy on the next clk, and enters WAIT.
REQ-022 TX WAIT: the next clk_en enters START and drives tx = 0.
REQ-023 TX bit cells: every bit (start, 8 data, stop) SHALL last exactly 2 clk_en periods.
REQ-024 TX end of frame: after the stop cell, return to IDLE and clear tx_busy.
REQ-025 tx_start while tx_busy is high SHALL be ignored.
REQ-026 Echo: rx_valid copies rx_data into a holding register and sets pending; pending && !tx_busy pulses tx_start for 1 clk and clears pending.
REQ-027 A new rx_valid while pending SHALL overwrite the holding register (last byte wins).
REQ-028 If rx_valid coincides with the pending-clear, the new byte SHALL stay pending.
REQ-029 Receive and transmit SHALL operate concurrently; an echo never blocks reception.

Reset
REQ-030 While rst is high: tx = 1, tx_busy = 0, rx_valid = 0, rx_frame_err = 0, rx_data = 0x00, pending = 0, divider counter = 0, synchronizer flops = 1, both FSMs in IDLE.
REQ-031 rst asserted mid-frame SHALL abort the frame immediately; tx returns high asynchronously, and reception resumes only at a new start edge after rst falls.

Structure
REQ-032 Package uart_pkg SHALL hold the RX/TX state enums, data width 8, and a DIV computation function.
REQ-033 Top uart_echo SHALL instantiate three sub-modules, clock_divider, uart_rx and uart_tx, sharing one clk_en; the echo logic lives in the top.

Verification
REQ-034 INPUT_CLOCK = 1000, BAUD_RATE = 50 -> clk_en every 10 clk, 1 clk wide, first at the 10th clk after rst falls.
REQ-035 INPUT_CLOCK = 16, BAUD_RATE = 1 (16 clk/bit), send 0x55 -> rx_valid pulses once with rx_data = 0x55; tx then emits 0,1,0,1,0,1,0,1,0,1, each 16 clk, with tx_busy high throughout.
REQ-036 Same parameters, rx low for 3 clk then high -> no rx_valid, no rx_frame_err, tx stays 1.
REQ-037 Same parameters, send 0xA5 with stop bit 0 -> rx_frame_err pulses once, no rx_valid, no echo, rx_data unchanged.
REQ-038 Same parameters, back-to-back 0xA5 then 0x3C -> two rx_valid pulses, and tx echoes 0xA5 then 0x3C in order.
REQ-039 Assert rst mid-echo of 0xFF -> tx = 1 and tx_busy = 0 in the same cycle; no output activity until the next received frame.
